// File: rtl/box_color_pkg.sv
// Shared definitions for the box-colour render path: widths, fade limits,
// the 32-entry palette and small arithmetic helpers used by the renderer.
package box_color_pkg;

    localparam int COLOR_IDX_W = 5;
    localparam int RGB_W       = 12;
    localparam int COORD_W     = 10;
    localparam int LVL_W       = 4;

    localparam logic [LVL_W-1:0] FADE_MAX = 4'd15;

    // Contents of the first pipeline stage.
    typedef struct packed {
        logic                   valid;
        logic                   hit;
        logic [COLOR_IDX_W-1:0] idx;
        logic [LVL_W-1:0]       lvl;
        logic [RGB_W-1:0]       rgb;
    } stage1_t;

    // Palette contents; index 0 is the hidden/black entry.
    function automatic logic [RGB_W-1:0] palette_color(input logic [COLOR_IDX_W-1:0] idx);
        logic [RGB_W-1:0] c;
        case (idx)
            5'd0:    c = 12'h000;
            5'd1:    c = 12'hF00;
            5'd2:    c = 12'h0F0;
            5'd3:    c = 12'h00F;
            5'd4:    c = 12'hFF0;
            5'd5:    c = 12'h0FF;
            5'd6:    c = 12'hF0F;
            5'd7:    c = 12'hFFF;
            5'd8:    c = 12'h888;
            5'd9:    c = 12'h800;
            5'd10:   c = 12'h080;
            5'd11:   c = 12'h008;
            5'd12:   c = 12'h880;
            5'd13:   c = 12'h088;
            5'd14:   c = 12'h808;
            5'd15:   c = 12'hF80;
            5'd16:   c = 12'hF08;
            5'd17:   c = 12'h8F0;
            5'd18:   c = 12'h0F8;
            5'd19:   c = 12'h80F;
            5'd20:   c = 12'h08F;
            5'd21:   c = 12'hFA5;
            5'd22:   c = 12'h5AF;
            5'd23:   c = 12'hA5F;
            5'd24:   c = 12'h444;
            5'd25:   c = 12'hCCC;
            5'd26:   c = 12'h963;
            5'd27:   c = 12'h369;
            5'd28:   c = 12'h693;
            5'd29:   c = 12'hF66;
            5'd30:   c = 12'h6F6;
            5'd31:   c = 12'h66F;
            default: c = 12'h000;
        endcase
        return c;
    endfunction

    // Saturating fade increment; never wraps past FADE_MAX.
    function automatic logic [LVL_W-1:0] fade_next(input logic [LVL_W-1:0] lvl,
                                                    input logic [LVL_W:0]   step);
        logic [LVL_W:0] sum;
        logic [LVL_W-1:0] res;
        sum = {1'b0, lvl} + step;
        if (sum > {1'b0, FADE_MAX}) begin
            res = FADE_MAX;
        end else begin
            res = sum[LVL_W-1:0];
        end
        return res;
    endfunction

    // Inclusive rectangle test, done in 11 bits so right/bottom edges near 1023 do not wrap.
    function automatic logic box_hit(input logic [COORD_W-1:0] px,
                                     input logic [COORD_W-1:0] py,
                                     input logic [COORD_W-1:0] bx,
                                     input logic [COORD_W-1:0] by,
                                     input logic [COORD_W:0]   w_m1,
                                     input logic [COORD_W:0]   h_m1);
        logic [COORD_W:0] x_end;
        logic [COORD_W:0] y_end;
        x_end = {1'b0, bx} + w_m1;
        y_end = {1'b0, by} + h_m1;
        return ({1'b0, px} >= {1'b0, bx}) && ({1'b0, px} <= x_end) &&
               ({1'b0, py} >= {1'b0, by}) && ({1'b0, py} <= y_end);
    endfunction

    // One colour channel scaled by (lvl+1)/16: 4b x 5b product, keep bits [7:4].
    function automatic logic [3:0] scale_chan(input logic [3:0] c, input logic [LVL_W-1:0] lvl);
        logic [8:0] prod;
        prod = 9'(c) * 9'({1'b0, lvl} + 5'd1);
        return prod[7:4];
    endfunction

endpackage

// File: rtl/box_palette_rom.sv
// Combinational palette lookup: 5-bit colour index to 12-bit RGB.
module box_palette_rom
    import box_color_pkg::*;
(
    input  logic [COLOR_IDX_W-1:0] idx,
    output logic [RGB_W-1:0]       rgb
);

    // Pure table lookup, no state.
    always_comb begin
        rgb = palette_color(idx);
    end

endmodule

// File: rtl/box_color_render.sv
// Renders two coloured boxes into the VGA pixel stream. Box indices and
// positions are latched once per frame; each box fades in after an index
// change. Fixed two-cycle latency from pixel coordinate to o_rgb.
module box_color_render
    import box_color_pkg::*;
#(
    parameter int               BOX_W     = 40,
    parameter int               BOX_H     = 40,
    parameter int               FADE_STEP = 1,
    parameter logic [RGB_W-1:0] BG_RGB    = 12'h000
) (
    input  logic                   clk_machine,
    input  logic                   rst_machine,
    input  logic                   i_frame_start,
    input  logic [COLOR_IDX_W-1:0] i_color_index1,
    input  logic [COLOR_IDX_W-1:0] i_color_index2,
    input  logic [COORD_W-1:0]     i_box1_x,
    input  logic [COORD_W-1:0]     i_box1_y,
    input  logic [COORD_W-1:0]     i_box2_x,
    input  logic [COORD_W-1:0]     i_box2_y,
    input  logic                   i_pix_valid,
    input  logic [COORD_W-1:0]     i_pix_x,
    input  logic [COORD_W-1:0]     i_pix_y,
    output logic [RGB_W-1:0]       o_rgb,
    output logic                   o_rgb_valid
);

    localparam logic [COORD_W:0] BOX_W_M1  = 11'(BOX_W - 1);
    localparam logic [COORD_W:0] BOX_H_M1  = 11'(BOX_H - 1);
    localparam logic [LVL_W:0]   FADE_INC  = 5'(FADE_STEP);

    // Per-frame latched state.
    logic [COLOR_IDX_W-1:0] cur_idx1_r;
    logic [COLOR_IDX_W-1:0] cur_idx2_r;
    logic [LVL_W-1:0]       lvl1_r;
    logic [LVL_W-1:0]       lvl2_r;
    logic [COORD_W-1:0]     box1_x_r;
    logic [COORD_W-1:0]     box1_y_r;
    logic [COORD_W-1:0]     box2_x_r;
    logic [COORD_W-1:0]     box2_y_r;

    // Stage-1 selection signals.
    logic                   hit1_s;
    logic                   hit2_s;
    logic                   sel_hit_s;
    logic [COLOR_IDX_W-1:0] sel_idx_s;
    logic [LVL_W-1:0]       sel_lvl_s;
    logic [RGB_W-1:0]       rom_rgb_s;
    stage1_t                s1_r;

    // Stage-2 result.
    logic [RGB_W-1:0]       out_rgb_s;

    // Frame latch: positions always captured; index change restarts the fade, else fade saturates upward.
    always_ff @(posedge clk_machine or posedge rst_machine) begin
        if (rst_machine) begin
            cur_idx1_r <= 5'd0;
            cur_idx2_r <= 5'd0;
            lvl1_r     <= FADE_MAX;
            lvl2_r     <= FADE_MAX;
            box1_x_r   <= 10'd0;
            box1_y_r   <= 10'd0;
            box2_x_r   <= 10'd0;
            box2_y_r   <= 10'd0;
        end else if (i_frame_start) begin
            box1_x_r <= i_box1_x;
            box1_y_r <= i_box1_y;
            box2_x_r <= i_box2_x;
            box2_y_r <= i_box2_y;
            if (i_color_index1 != cur_idx1_r) begin
                cur_idx1_r <= i_color_index1;
                lvl1_r     <= 4'd0;
            end else begin
                lvl1_r     <= fade_next(lvl1_r, FADE_INC);
            end
            if (i_color_index2 != cur_idx2_r) begin
                cur_idx2_r <= i_color_index2;
                lvl2_r     <= 4'd0;
            end else begin
                lvl2_r     <= fade_next(lvl2_r, FADE_INC);
            end
        end else begin
            cur_idx1_r <= cur_idx1_r;
            cur_idx2_r <= cur_idx2_r;
            lvl1_r     <= lvl1_r;
            lvl2_r     <= lvl2_r;
            box1_x_r   <= box1_x_r;
            box1_y_r   <= box1_y_r;
            box2_x_r   <= box2_x_r;
            box2_y_r   <= box2_y_r;
        end
    end

    // Hit test against the latched boxes; a box with index 0 is hidden.
    always_comb begin
        hit1_s = (cur_idx1_r != 5'd0) &&
                 box_hit(i_pix_x, i_pix_y, box1_x_r, box1_y_r, BOX_W_M1, BOX_H_M1);
        hit2_s = (cur_idx2_r != 5'd0) &&
                 box_hit(i_pix_x, i_pix_y, box2_x_r, box2_y_r, BOX_W_M1, BOX_H_M1);
    end

    // Box 2 drawn on top when both boxes cover the pixel.
    always_comb begin
        sel_hit_s = 1'b0;
        sel_idx_s = 5'd0;
        sel_lvl_s = 4'd0;
        if (hit2_s) begin
            sel_hit_s = 1'b1;
            sel_idx_s = cur_idx2_r;
            sel_lvl_s = lvl2_r;
        end else if (hit1_s) begin
            sel_hit_s = 1'b1;
            sel_idx_s = cur_idx1_r;
            sel_lvl_s = lvl1_r;
        end else begin
            sel_hit_s = 1'b0;
            sel_idx_s = 5'd0;
            sel_lvl_s = 4'd0;
        end
    end

    box_palette_rom u_palette (
        .idx (sel_idx_s),
        .rgb (rom_rgb_s)
    );

    // Stage 1: register the hit decision, selected fade level and palette colour.
    always_ff @(posedge clk_machine or posedge rst_machine) begin
        if (rst_machine) begin
            s1_r <= '0;
        end else begin
            s1_r.valid <= i_pix_valid;
            s1_r.hit   <= sel_hit_s;
            s1_r.idx   <= sel_idx_s;
            s1_r.lvl   <= sel_lvl_s;
            s1_r.rgb   <= rom_rgb_s;
        end
    end

    // Stage 2 combinational: fade scaling, background fill, blanking of invalid slots.
    always_comb begin
        out_rgb_s = 12'h000;
        if (!s1_r.valid) begin
            out_rgb_s = 12'h000;
        end else if (s1_r.hit && (s1_r.idx != 5'd0)) begin
            out_rgb_s = {scale_chan(s1_r.rgb[11:8], s1_r.lvl),
                         scale_chan(s1_r.rgb[7:4],  s1_r.lvl),
                         scale_chan(s1_r.rgb[3:0],  s1_r.lvl)};
        end else begin
            out_rgb_s = BG_RGB;
        end
    end

    // Stage 2 output register.
    always_ff @(posedge clk_machine or posedge rst_machine) begin
        if (rst_machine) begin
            o_rgb       <= 12'h000;
            o_rgb_valid <= 1'b0;
        end else begin
            o_rgb       <= out_rgb_s;
            o_rgb_valid <= s1_r.valid;
        end
    end

endmodule
